perf_counter_master: RTL and testbench

PERF_COUNTER_MASTER -- requirements
Module: perf_counter_master

---
 rtl/perf_counter_master_if.sv | 39 +++
 rtl/perf_counter_master.sv | 134 +++++++++++++
 tb/tb_perf_counter_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_counter_master_if.sv
// rtl/perf_counter_master_if.sv - command, result and Avalon-MM bundle for perf_counter_master
//
// Purpose: groups the command handshake, the READ result outputs and the
// Avalon-MM master bus of perf_counter_master into one interface.
// Modports:
//   master - the perf_counter_master side (drives cmd_ready, results, avm_* requests)
//   slave  - the command source / counter slave side (drives cmd_*, avm_readdata, avm_waitrequest)
// Signals:
//   cmd_valid, cmd_ready, cmd_op[1:0], cmd_sect     command handshake
//   result_valid, time_count[63:0], event_count[31:0] READ results
//   avm_address[2:0], avm_write, avm_read, avm_writedata[31:0],
//   avm_readdata[31:0], avm_waitrequest              counter slave bus
interface perf_counter_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_sect;
  logic        result_valid;
  logic [63:0] time_count;
  logic [31:0] event_count;
  logic [2:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_op, cmd_sect, avm_readdata, avm_waitrequest,
    output cmd_ready, result_valid, time_count, event_count,
           avm_address, avm_write, avm_read, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sect, avm_readdata, avm_waitrequest,
    input  cmd_ready, result_valid, time_count, event_count,
           avm_address, avm_write, avm_read, avm_writedata
  );
endinterface

// File: rtl/perf_counter_master.sv
// rtl/perf_counter_master.sv - sequences perf counter commands onto an Avalon-MM slave
//
// Purpose: accepts GO / STOP / CLEAR_ALL / READ commands for one of two counter
// sections and turns each into bus cycles. GO/STOP/CLEAR_ALL are single writes;
// READ is three sequential reads (time low, time high, event count) whose data
// is committed to time_count/event_count together with a one-cycle result_valid.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high
//   bus    - perf_counter_master_if.master (command, result and avm_* signals)
// Parameter:
//   READ_LATENCY - cycles from read acceptance to valid avm_readdata (1..4)
module perf_counter_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  perf_counter_master_if.master         bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

  localparam logic [1:0] OP_GO    = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;
  localparam logic [2:0] LAT      = 3'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic        sect_q;
  logic [1:0]  rd_idx_q;
  logic [2:0]  lat_q;
  logic [31:0] sh_lo_q, sh_hi_q;
  logic [63:0] time_q;
  logic [31:0] event_q;
  logic [2:0]  base;
  logic        accept, rd_accept, capture;

  assign base = {sect_q, 2'b00};
  assign bus.time_count  = time_q;
  assign bus.event_count = event_q;

  always_comb begin
    state_d           = state_q;
    bus.cmd_ready     = 1'b0;
    bus.avm_write     = 1'b0;
    bus.avm_read      = 1'b0;
    bus.avm_address   = 3'd0;
    bus.avm_writedata = 32'd0;
    bus.result_valid  = 1'b0;
    accept            = 1'b0;
    rd_accept         = 1'b0;
    capture           = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = (bus.cmd_op == OP_READ) ? RD_REQ : WR;
        end
      end
      WR: begin
        bus.avm_write = 1'b1;
        case (op_q)
          OP_GO:    bus.avm_address = base + 3'd1;
          OP_STOP:  bus.avm_address = base;
          OP_CLEAR: begin
            bus.avm_address   = 3'd0;
            bus.avm_writedata = 32'd1;
          end
          default:  bus.avm_address = base;
        endcase
        if (!bus.avm_waitrequest) state_d = IDLE;
      end
      RD_REQ: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = base + {1'b0, rd_idx_q};
        if (!bus.avm_waitrequest) begin
          rd_accept = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // lat_q counts cycles since the read was accepted; data is valid when it reaches LAT
        if (lat_q == LAT) begin
          capture = 1'b1;
          state_d = (rd_idx_q == 2'd2) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        bus.result_valid = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      sect_q   <= 1'b0;
      rd_idx_q <= 2'd0;
      lat_q    <= 3'd0;
      sh_lo_q  <= 32'd0;
      sh_hi_q  <= 32'd0;
      time_q   <= 64'd0;
      event_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= bus.cmd_op;
        sect_q   <= bus.cmd_sect;
        rd_idx_q <= 2'd0;
      end
      if (rd_accept) lat_q <= 3'd1;
      else if (state_q == RD_WAIT && !capture) lat_q <= lat_q + 3'd1;
      // Partial words go to shadows so the visible counts only change when a READ completes
      if (capture) begin
        rd_idx_q <= rd_idx_q + 2'd1;
        case (rd_idx_q)
          2'd0:    sh_lo_q <= bus.avm_readdata;
          2'd1:    sh_hi_q <= bus.avm_readdata;
          default: begin
            time_q  <= {sh_hi_q, sh_lo_q};
            event_q <= bus.avm_readdata;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_master.sv
// tb/tb_perf_counter_master.sv - self-checking bench for perf_counter_master
module tb_perf_counter_master;

  typedef struct packed {logic wr; logic [2:0] addr; logic [31:0] data;} xfer_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  perf_counter_master_if a_if();
  perf_counter_master_if b_if();

  perf_counter_master #(.READ_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  perf_counter_master #(.READ_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] a_mem [8];
  logic [31:0] b_mem [8];
  xfer_t a_log[$], b_log[$], exp_q[$];
  logic [1:0] a_acc_op[$];
  int a_pend = 0, b_pend = 0;
  logic [2:0] a_paddr = 3'd0, b_paddr = 3'd0;
  int a_stall = 0, a_wcnt = 0;
  bit a_rand = 1'b0, a_rbit = 1'b0, b_rbit = 1'b0;
  int a_over = 0, a_outst = 0, a_idle_err = 0, b_over = 0, b_outst = 0;
  int a_acc_n = 0, a_acc_cyc = 0, a_rv_n = 0, a_rv_cyc = 0, b_acc_n = 0, b_rv_n = 0;
  logic [63:0] exp_tc = 64'd0;
  logic [31:0] exp_ec = 32'd0;

  // Slave models: random or forced stalls, read data only valid exactly READ_LATENCY cycles after acceptance
  assign a_if.avm_waitrequest = (a_if.avm_read | a_if.avm_write) & ((a_wcnt < a_stall) | (a_rand & a_rbit));
  assign a_if.avm_readdata    = (a_pend == 1) ? a_mem[a_paddr] : 32'hDEAD_BEEF;
  assign b_if.avm_waitrequest = (b_if.avm_read | b_if.avm_write) & b_rbit;
  assign b_if.avm_readdata    = (b_pend == 3) ? b_mem[b_paddr] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_rbit <= 1'($urandom_range(0, 1));
    if (a_if.avm_read && a_if.avm_write) a_over <= a_over + 1;
    if (!a_if.avm_read && !a_if.avm_write && (a_if.avm_address != 3'd0 || a_if.avm_writedata != 32'd0))
      a_idle_err <= a_idle_err + 1;
    if ((a_if.avm_read || a_if.avm_write) && a_if.avm_waitrequest) a_wcnt <= a_wcnt + 1;
    else a_wcnt <= 0;
    if (!reset && (a_if.avm_read || a_if.avm_write) && !a_if.avm_waitrequest) begin
      a_log.push_back({a_if.avm_write, a_if.avm_address, a_if.avm_writedata});
      if (a_pend != 0) a_outst <= a_outst + 1;
    end
    if (reset) a_pend <= 0;
    else if (a_if.avm_read && !a_if.avm_waitrequest) begin a_pend <= 1; a_paddr <= a_if.avm_address; end
    else if (a_pend == 1) a_pend <= 0;
    else if (a_pend != 0) a_pend <= a_pend + 1;
    if (!reset && a_if.cmd_valid && a_if.cmd_ready) begin
      a_acc_n <= a_acc_n + 1; a_acc_cyc <= cyc; a_acc_op.push_back(a_if.cmd_op);
    end
    if (a_if.result_valid) begin a_rv_n <= a_rv_n + 1; a_rv_cyc <= cyc; end
  end

  always @(posedge clk) begin
    b_rbit <= 1'($urandom_range(0, 1));
    if (b_if.avm_read && b_if.avm_write) b_over <= b_over + 1;
    if (!reset && (b_if.avm_read || b_if.avm_write) && !b_if.avm_waitrequest) begin
      b_log.push_back({b_if.avm_write, b_if.avm_address, b_if.avm_writedata});
      if (b_pend != 0) b_outst <= b_outst + 1;
    end
    if (reset) b_pend <= 0;
    else if (b_if.avm_read && !b_if.avm_waitrequest) begin b_pend <= 1; b_paddr <= b_if.avm_address; end
    else if (b_pend == 3) b_pend <= 0;
    else if (b_pend != 0) b_pend <= b_pend + 1;
    if (!reset && b_if.cmd_valid && b_if.cmd_ready) b_acc_n <= b_acc_n + 1;
    if (b_if.result_valid) b_rv_n <= b_rv_n + 1;
  end

  // Reference model: bus transfers implied by a command, and the counts a READ must return
  task automatic model_push(input logic [1:0] op, input logic s);
    logic [2:0] b;
    b = {s, 2'b00};
    case (op)
      2'd0: exp_q.push_back({1'b1, b + 3'd1, 32'd0});
      2'd1: exp_q.push_back({1'b1, b, 32'd0});
      2'd2: exp_q.push_back({1'b1, 3'd0, 32'd1});
      default: for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, b + 3'(k), 32'd0});
    endcase
  endtask

  task automatic model_read(input logic [31:0] m [8], input logic s);
    int b;
    b = s ? 4 : 0;
    exp_tc = (64'(m[b + 1]) << 32) | 64'(m[b]);
    exp_ec = m[b + 2];
  endtask

  task automatic a_issue(input logic [1:0] op, input logic s, output bit ok);
    int n0, t;
    n0 = a_acc_n; t = 0;
    a_if.cmd_valid = 1'b1; a_if.cmd_op = op; a_if.cmd_sect = s;
    while (a_acc_n == n0 && t < 50) begin @(posedge clk); #1; t++; end
    a_if.cmd_valid = 1'b0;
    ok = (a_acc_n != n0);
  endtask

  task automatic a_wait_idle(output bit ok);
    int t;
    t = 0;
    while (a_if.cmd_ready !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    ok = (a_if.cmd_ready === 1'b1);
  endtask

  task automatic test_reset;
    a_if.cmd_valid = 1'b0; a_if.cmd_op = 2'd0; a_if.cmd_sect = 1'b0;
    b_if.cmd_valid = 1'b0; b_if.cmd_op = 2'd0; b_if.cmd_sect = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0h exp=1", a_if.cmd_ready); end
    checks++; if ({a_if.avm_read, a_if.avm_write} !== 2'b00) begin failures++; $display("FAIL reset_rd_wr got=%0h exp=0", {a_if.avm_read, a_if.avm_write}); end
    checks++; if ({a_if.avm_address, a_if.avm_writedata} !== 35'd0) begin failures++; $display("FAIL reset_addr_data got=%0h exp=0", {a_if.avm_address, a_if.avm_writedata}); end
    checks++; if (a_if.result_valid !== 1'b0) begin failures++; $display("FAIL reset_result_valid got=%0h exp=0", a_if.result_valid); end
    checks++; if ({a_if.time_count, a_if.event_count} !== 96'd0) begin failures++; $display("FAIL reset_counts got=%0h exp=0", {a_if.time_count, a_if.event_count}); end
    checks++; if ({b_if.cmd_ready, b_if.avm_read, b_if.avm_write, b_if.result_valid} !== 4'b1000) begin failures++; $display("FAIL reset_b_ctrl got=%0h exp=8", {b_if.cmd_ready, b_if.avm_read, b_if.avm_write, b_if.result_valid}); end
    reset = 1'b0;
  endtask

  task automatic test_go_sect1;
    bit ok;
    int s, lo;
    s = a_log.size(); lo = 0;
    a_issue(2'd0, 1'b1, ok);
    for (int i = 0; i < 5; i++) begin if (a_if.cmd_ready === 1'b0) lo++; @(posedge clk); #1; end
    checks++; if (!ok) begin failures++; $display("FAIL go_accept got=0 exp=1"); end
    checks++; if (lo != 1) begin failures++; $display("FAIL go_ready_low_cycles got=%0d exp=1", lo); end
    checks++; if (a_log.size() != s + 1 || a_log[s] !== {1'b1, 3'd5, 32'd0}) begin failures++; $display("FAIL go_write got=%0h exp=%0h n=%0d", a_log[s], {1'b1, 3'd5, 32'd0}, a_log.size() - s); end
  endtask

  task automatic test_clear_stall;
    bit ok;
    int s, held, bad;
    s = a_log.size(); held = 0; bad = 0;
    a_stall = 3;
    a_issue(2'd2, 1'b1, ok);
    for (int i = 0; i < 10; i++) begin
      if (a_if.avm_write === 1'b1) begin
        held++;
        if (a_if.avm_address !== 3'd0 || a_if.avm_writedata !== 32'd1 || a_if.avm_read !== 1'b0) bad++;
      end
      @(posedge clk); #1;
    end
    a_stall = 0;
    checks++; if (!ok) begin failures++; $display("FAIL clear_accept got=0 exp=1"); end
    checks++; if (held != 4) begin failures++; $display("FAIL clear_write_held got=%0d exp=4", held); end
    checks++; if (bad != 0) begin failures++; $display("FAIL clear_stable got=%0d exp=0", bad); end
    checks++; if (a_log.size() != s + 1 || a_log[s] !== {1'b1, 3'd0, 32'd1}) begin failures++; $display("FAIL clear_write got=%0h exp=%0h", a_log[s], {1'b1, 3'd0, 32'd1}); end
  endtask

  task automatic test_read_fixed;
    bit ok, ok2;
    int s, rv0, n_bad;
    a_mem[0] = 32'h1111_1111; a_mem[1] = 32'h0000_0002; a_mem[2] = 32'h0000_0033;
    s = a_log.size(); rv0 = a_rv_n;
    exp_q.delete(); model_push(2'd3, 1'b0); model_read(a_mem, 1'b0);
    a_issue(2'd3, 1'b0, ok);
    a_wait_idle(ok2);
    n_bad = 0;
    for (int k = 0; k < exp_q.size(); k++) if (s + k >= a_log.size() || a_log[s + k] !== exp_q[k]) n_bad++;
    checks++; if (!(ok && ok2)) begin failures++; $display("FAIL read_handshake got=%0d%0d exp=11", ok, ok2); end
    checks++; if (a_if.time_count !== 64'h0000_0002_1111_1111) begin failures++; $display("FAIL read_time got=%0h exp=0000000211111111", a_if.time_count); end
    checks++; if (a_if.event_count !== 32'h33) begin failures++; $display("FAIL read_event got=%0h exp=33", a_if.event_count); end
    checks++; if (a_rv_n - rv0 != 1) begin failures++; $display("FAIL read_pulses got=%0d exp=1", a_rv_n - rv0); end
    checks++; if (a_rv_cyc - a_acc_cyc != 7) begin failures++; $display("FAIL read_latency got=%0d exp=7", a_rv_cyc - a_acc_cyc); end
    checks++; if (a_log.size() != s + 3 || n_bad != 0) begin failures++; $display("FAIL read_bus got=%0d/%0d exp=3/0", a_log.size() - s, n_bad); end
    exp_tc = 64'h0000_0002_1111_1111; exp_ec = 32'h33;
  endtask

  task automatic test_random_cmds;
    bit ok, ok2;
    int s, rv0, n_bad;
    logic [1:0] op;
    logic sect;
    a_rand = 1'b1;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 8; k++) a_mem[k] = $urandom;
      op = 2'($urandom_range(0, 3)); sect = 1'($urandom_range(0, 1));
      exp_q.delete(); model_push(op, sect);
      if (op == 2'd3) model_read(a_mem, sect);
      s = a_log.size(); rv0 = a_rv_n;
      a_issue(op, sect, ok);
      a_wait_idle(ok2);
      n_bad = 0;
      for (int k = 0; k < exp_q.size(); k++) if (s + k >= a_log.size() || a_log[s + k] !== exp_q[k]) n_bad++;
      checks++; if (!(ok && ok2)) begin failures++; $display("FAIL rand_handshake it=%0d got=%0d%0d exp=11", it, ok, ok2); end
      checks++; if (a_log.size() != s + exp_q.size() || n_bad != 0) begin failures++; $display("FAIL rand_bus it=%0d op=%0d got=%0d/%0d exp=%0d/0", it, op, a_log.size() - s, n_bad, exp_q.size()); end
      checks++; if (a_if.time_count !== exp_tc || a_if.event_count !== exp_ec) begin failures++; $display("FAIL rand_counts it=%0d got=%0h/%0h exp=%0h/%0h", it, a_if.time_count, a_if.event_count, exp_tc, exp_ec); end
      checks++; if (a_rv_n - rv0 != ((op == 2'd3) ? 1 : 0)) begin failures++; $display("FAIL rand_pulses it=%0d got=%0d exp=%0d", it, a_rv_n - rv0, (op == 2'd3) ? 1 : 0); end
    end
    a_rand = 1'b0;
    checks++; if (a_over != 0 || a_outst != 0 || a_idle_err != 0) begin failures++; $display("FAIL bus_protocol got=%0d/%0d/%0d exp=0/0/0", a_over, a_outst, a_idle_err); end
  endtask

  task automatic test_latency3;
    int s, rv0, t, n0, n_bad;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 8; k++) b_mem[k] = $urandom;
      exp_q.delete(); model_push(2'd3, 1'b1);
      s = b_log.size(); rv0 = b_rv_n; n0 = b_acc_n; t = 0;
      b_if.cmd_valid = 1'b1; b_if.cmd_op = 2'd3; b_if.cmd_sect = 1'b1;
      while (b_acc_n == n0 && t < 50) begin @(posedge clk); #1; t++; end
      b_if.cmd_valid = 1'b0;
      while (b_if.cmd_ready !== 1'b1 && t < 300) begin @(posedge clk); #1; t++; end
      n_bad = 0;
      for (int k = 0; k < exp_q.size(); k++) if (s + k >= b_log.size() || b_log[s + k] !== exp_q[k]) n_bad++;
      checks++; if (b_if.cmd_ready !== 1'b1 || b_acc_n == n0) begin failures++; $display("FAIL lat3_timeout it=%0d got=%0d exp=1", it, b_if.cmd_ready); end
      checks++; if (b_log.size() != s + 3 || n_bad != 0) begin failures++; $display("FAIL lat3_bus it=%0d got=%0d/%0d exp=3/0", it, b_log.size() - s, n_bad); end
      checks++; if (b_if.time_count !== {b_mem[5], b_mem[4]} || b_if.event_count !== b_mem[6]) begin failures++; $display("FAIL lat3_counts it=%0d got=%0h/%0h exp=%0h/%0h", it, b_if.time_count, b_if.event_count, {b_mem[5], b_mem[4]}, b_mem[6]); end
      checks++; if (b_rv_n - rv0 != 1) begin failures++; $display("FAIL lat3_pulses it=%0d got=%0d exp=1", it, b_rv_n - rv0); end
    end
    checks++; if (b_over != 0 || b_outst != 0) begin failures++; $display("FAIL lat3_protocol got=%0d/%0d exp=0/0", b_over, b_outst); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int t, rv0;
    bit found;
    for (int k = 0; k < 8; k++) a_mem[k] = $urandom;
    a_issue(2'd3, 1'b0, ok);
    t = 0; found = 1'b0;
    while (!found && t < 20) begin
      if (a_if.avm_read === 1'b1 && a_if.avm_address === 3'd1) found = 1'b1;
      else begin @(posedge clk); #1; t++; end
    end
    checks++; if (!(ok && found)) begin failures++; $display("FAIL rstmid_second_read got=%0d%0d exp=11", ok, found); end
    rv0 = a_rv_n;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({a_if.avm_read, a_if.avm_write, a_if.avm_address, a_if.avm_writedata} !== 37'd0) begin failures++; $display("FAIL rstmid_bus_idle got=%0h exp=0", {a_if.avm_read, a_if.avm_write, a_if.avm_address, a_if.avm_writedata}); end
    checks++; if ({a_if.time_count, a_if.event_count} !== 96'd0) begin failures++; $display("FAIL rstmid_counts got=%0h exp=0", {a_if.time_count, a_if.event_count}); end
    checks++; if (a_if.cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_cmd_ready got=%0h exp=1", a_if.cmd_ready); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (a_rv_n != rv0) begin failures++; $display("FAIL rstmid_no_result got=%0d exp=0", a_rv_n - rv0); end
    exp_tc = 64'd0; exp_ec = 32'd0;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int s, n0, t, n_bad, q0;
    for (int k = 0; k < 8; k++) a_mem[k] = $urandom;
    exp_q.delete(); model_push(2'd3, 1'b1); model_push(2'd0, 1'b0); model_read(a_mem, 1'b1);
    s = a_log.size(); q0 = a_acc_op.size(); n0 = a_acc_n; t = 0;
    a_rand = 1'b1;
    a_if.cmd_valid = 1'b1; a_if.cmd_op = 2'd3; a_if.cmd_sect = 1'b1;
    while (a_acc_n == n0 && t < 50) begin @(posedge clk); #1; t++; end
    a_if.cmd_op = 2'd0; a_if.cmd_sect = 1'b0;
    while (a_acc_n < n0 + 2 && t < 300) begin @(posedge clk); #1; t++; end
    a_if.cmd_valid = 1'b0;
    a_wait_idle(ok);
    a_rand = 1'b0;
    n_bad = 0;
    for (int k = 0; k < exp_q.size(); k++) if (s + k >= a_log.size() || a_log[s + k] !== exp_q[k]) n_bad++;
    checks++; if (a_acc_n != n0 + 2 || !ok) begin failures++; $display("FAIL b2b_accepts got=%0d exp=2", a_acc_n - n0); end
    checks++; if (a_acc_cyc <= a_rv_cyc) begin failures++; $display("FAIL b2b_accept_after_result got=%0d exp=>%0d", a_acc_cyc, a_rv_cyc); end
    checks++; if (a_acc_op.size() != q0 + 2 || a_acc_op[q0] !== 2'd3 || a_acc_op[q0 + 1] !== 2'd0) begin failures++; $display("FAIL b2b_ops got=%0d exp=2", a_acc_op.size() - q0); end
    checks++; if (a_log.size() != s + 4 || n_bad != 0) begin failures++; $display("FAIL b2b_bus got=%0d/%0d exp=4/0", a_log.size() - s, n_bad); end
    checks++; if (a_if.time_count !== exp_tc || a_if.event_count !== exp_ec) begin failures++; $display("FAIL b2b_counts got=%0h/%0h exp=%0h/%0h", a_if.time_count, a_if.event_count, exp_tc, exp_ec); end
    checks++; if (a_over != 0 || a_outst != 0 || a_idle_err != 0) begin failures++; $display("FAIL b2b_protocol got=%0d/%0d/%0d exp=0/0/0", a_over, a_outst, a_idle_err); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin a_mem[k] = 32'd0; b_mem[k] = 32'd0; end
    test_reset;
    test_go_sect1;
    test_clear_stall;
    test_read_fixed;
    test_random_cmds;
    test_latency3;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
